hdmi_packet_sorter: RTL and testbench

- Receive-side counterpart of the HDMI TX packet selection logic.
- Takes fully deframed, ECC-checked data-island packets from the RX deframer and dispatches them by packet type:
  - ACR (0x01) -> N/CTS registers.
  - Audio Sample (0x02) -> sample stream.
  - GCP (0x03) -> AVMUTE and deep-colour state.
  - AVI InfoFrame (0x82) -> VIC capture, checksum check, presence timeout.
- Sits between the TMDS data-island deframer and the RX audio/video control blocks.

---
 rtl/hdmi_packet_sorter.sv | 174 +++++++++++++++++
 tb/tb_hdmi_packet_sorter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_packet_sorter.sv
// Receive-side data-island packet dispatcher: routes deframed, ECC-checked packets to
// ACR, GCP, AVI and audio-sample consumers through a two-stage pipeline.
module hdmi_packet_sorter #(
    parameter int AUDIO_BIT_WIDTH = 16
) (
    input  logic                       clk_pixel,
    input  logic                       reset,
    input  logic                       pkt_valid,
    input  logic [23:0]                pkt_header,
    input  logic [223:0]               pkt_sub,
    input  logic                       pkt_ecc_err,
    input  logic                       video_field_end,
    output logic [19:0]                acr_N,
    output logic [19:0]                acr_CTS,
    output logic                       acr_update,
    output logic                       avmute,
    output logic [3:0]                 gcp_cd_field,
    output logic [3:0]                 gcp_pp_field,
    output logic [6:0]                 vic,
    output logic                       avi_valid,
    output logic                       avi_checksum_err,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    output logic [AUDIO_BIT_WIDTH-1:0] sample_left,
    output logic [AUDIO_BIT_WIDTH-1:0] sample_right,
    output logic                       sample_overflow,
    output logic [7:0]                 ecc_drop_count
);

    localparam logic [7:0] TYPE_ACR   = 8'h01;
    localparam logic [7:0] TYPE_AUDIO = 8'h02;
    localparam logic [7:0] TYPE_GCP   = 8'h03;
    localparam logic [7:0] TYPE_AVI   = 8'h82;

    function automatic logic [7:0] byte_sum(input logic [23:0] hdr, input logic [223:0] sub);
        logic [7:0] s;
        s = hdr[7:0] + hdr[15:8] + hdr[23:16];
        for (int i = 0; i < 28; i++) begin
            s = s + sub[8*i +: 8];
        end
        return s;
    endfunction

    function automatic logic [1:0] first_set(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else if (m[3]) return 2'd3;
        else           return 2'd0;
    endfunction

    // Keep the most significant AUDIO_BIT_WIDTH bits of a 24-bit two's-complement sample.
    function automatic logic signed [AUDIO_BIT_WIDTH-1:0] trunc_sample(input logic signed [23:0] s);
        return s[23 -: AUDIO_BIT_WIDTH];
    endfunction

    logic              vld_p1;
    logic              ecc_drop_p1;
    logic [7:0]        type_p1;
    logic [3:0]        present_p1;
    logic [55:0]       sub0_p1;
    logic [2:0][47:0]  aud_hi_p1;
    logic [7:0]        sum_p1;

    // Stage 1: capture the packet and precompute the AVI byte sum.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            ecc_drop_p1 <= 1'b0;
            type_p1     <= '0;
            present_p1  <= '0;
            sub0_p1     <= '0;
            aud_hi_p1   <= '0;
            sum_p1      <= '0;
        end else begin
            vld_p1      <= pkt_valid & ~pkt_ecc_err;
            ecc_drop_p1 <= pkt_valid & pkt_ecc_err;
            if (pkt_valid) begin
                type_p1    <= pkt_header[7:0];
                present_p1 <= pkt_header[11:8];
                sub0_p1    <= pkt_sub[55:0];
                for (int k = 1; k < 4; k++) begin
                    aud_hi_p1[k-1] <= pkt_sub[56*k +: 48];
                end
                sum_p1 <= byte_sum(pkt_header, pkt_sub);
            end
        end
    end

    logic             is_acr, is_gcp, is_avi, is_aud, avi_pass;
    logic             gcp_set, gcp_clr;
    logic [1:0]       field_cnt;
    logic [3:0]       pend_mask;
    logic [3:0][47:0] aud_hold;
    logic [1:0]       cur_idx;
    logic             handshake;
    logic [3:0]       mask_after;
    logic             aud_load, aud_ovf;

    always_comb begin
        is_acr     = vld_p1 && (type_p1 == TYPE_ACR);
        is_gcp     = vld_p1 && (type_p1 == TYPE_GCP);
        is_avi     = vld_p1 && (type_p1 == TYPE_AVI);
        is_aud     = vld_p1 && (type_p1 == TYPE_AUDIO);
        avi_pass   = is_avi && (sum_p1 == 8'h00);
        gcp_set    = sub0_p1[0] & ~sub0_p1[4];
        gcp_clr    = sub0_p1[4] & ~sub0_p1[0];
        cur_idx    = first_set(pend_mask);
        handshake  = sample_valid & sample_ready;
        mask_after = pend_mask & ~(handshake ? (4'b0001 << cur_idx) : 4'b0000);
        // A new packet may only replace the holding register once the old one is fully drained.
        aud_load   = is_aud && (present_p1 != 4'd0) && (mask_after == 4'd0);
        aud_ovf    = is_aud && (present_p1 != 4'd0) && (mask_after != 4'd0);
    end

    assign sample_valid = (pend_mask != 4'd0);
    assign sample_left  = trunc_sample(aud_hold[cur_idx][23:0]);
    assign sample_right = trunc_sample(aud_hold[cur_idx][47:24]);
    assign avi_valid    = (field_cnt < 2'd2);

    // Stage 2: decode into the output registers and the audio holding register.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            acr_N            <= '0;
            acr_CTS          <= '0;
            acr_update       <= 1'b0;
            avmute           <= 1'b0;
            gcp_cd_field     <= '0;
            gcp_pp_field     <= '0;
            vic              <= '0;
            avi_checksum_err <= 1'b0;
            field_cnt        <= 2'd2;
            ecc_drop_count   <= '0;
            pend_mask        <= '0;
            aud_hold         <= '0;
            sample_overflow  <= 1'b0;
        end else begin
            acr_update       <= is_acr;
            avi_checksum_err <= is_avi && (sum_p1 != 8'h00);
            if (is_acr) begin
                acr_CTS <= {sub0_p1[11:8], sub0_p1[23:16], sub0_p1[31:24]};
                acr_N   <= {sub0_p1[35:32], sub0_p1[47:40], sub0_p1[55:48]};
            end
            if (is_gcp) begin
                gcp_cd_field <= sub0_p1[11:8];
                gcp_pp_field <= sub0_p1[15:12];
                if (gcp_set)      avmute <= 1'b1;
                else if (gcp_clr) avmute <= 1'b0;
            end
            if (avi_pass) begin
                vic       <= sub0_p1[38:32];
                field_cnt <= 2'd0;
            end else if (video_field_end && (field_cnt != 2'd2)) begin
                field_cnt <= field_cnt + 2'd1;
            end
            if (ecc_drop_p1 && (ecc_drop_count != 8'hFF)) begin
                ecc_drop_count <= ecc_drop_count + 8'd1;
            end
            if (aud_load) begin
                pend_mask   <= present_p1;
                aud_hold[0] <= sub0_p1[47:0];
                for (int k = 1; k < 4; k++) begin
                    aud_hold[k] <= aud_hi_p1[k-1];
                end
            end else begin
                pend_mask <= mask_after;
            end
            if (aud_ovf) begin
                sample_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_packet_sorter.sv
// Bench for hdmi_packet_sorter: packet-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_hdmi_packet_sorter;

    localparam int AW = 16;

    logic          clk_pixel = 1'b0;
    logic          reset = 1'b1;
    logic          pkt_valid = 1'b0;
    logic [23:0]   pkt_header = '0;
    logic [223:0]  pkt_sub = '0;
    logic          pkt_ecc_err = 1'b0;
    logic          video_field_end = 1'b0;
    logic          sample_ready = 1'b0;
    logic [19:0]   acr_N, acr_CTS;
    logic          acr_update, avmute, avi_valid, avi_checksum_err;
    logic [3:0]    gcp_cd_field, gcp_pp_field;
    logic [6:0]    vic;
    logic          sample_valid, sample_overflow;
    logic [AW-1:0] sample_left, sample_right;
    logic [7:0]    ecc_drop_count;

    int checks = 0;
    int errors = 0;

    hdmi_packet_sorter #(.AUDIO_BIT_WIDTH(AW)) dut (
        .clk_pixel(clk_pixel), .reset(reset), .pkt_valid(pkt_valid),
        .pkt_header(pkt_header), .pkt_sub(pkt_sub), .pkt_ecc_err(pkt_ecc_err),
        .video_field_end(video_field_end), .acr_N(acr_N), .acr_CTS(acr_CTS),
        .acr_update(acr_update), .avmute(avmute), .gcp_cd_field(gcp_cd_field),
        .gcp_pp_field(gcp_pp_field), .vic(vic), .avi_valid(avi_valid),
        .avi_checksum_err(avi_checksum_err), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample_left(sample_left),
        .sample_right(sample_right), .sample_overflow(sample_overflow),
        .ecc_drop_count(ecc_drop_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sub_byte(input logic [223:0] s, input int k, input int i);
        return s[56*k + 8*i +: 8];
    endfunction

    // Reference model: packet effects land one edge after capture; audio is a sample queue.
    typedef struct packed { logic [23:0] l; logic [23:0] r; } smp_t;
    smp_t         mq[$];
    logic [19:0]  m_n = '0, m_cts = '0;
    logic         m_upd = 0, m_avmute = 0, m_cerr = 0, m_ovf = 0;
    logic [3:0]   m_cd = '0, m_pp = '0;
    logic [6:0]   m_vic = '0;
    int           m_fields = 2;
    int           m_ecc = 0;
    logic         m_have = 0, m_have_ecc = 0;
    logic [23:0]  m_hdr = '0;
    logic [223:0] m_sub = '0;

    always @(posedge clk_pixel or posedge reset) begin : model
        logic [7:0] sum, b0, b1;
        logic [3:0] pres;
        logic       avi_ok;
        smp_t       e;
        if (reset) begin
            mq.delete();
            m_n = '0; m_cts = '0; m_upd = 0; m_avmute = 0; m_cerr = 0; m_ovf = 0;
            m_cd = '0; m_pp = '0; m_vic = '0; m_fields = 2; m_ecc = 0;
            m_have = 0; m_have_ecc = 0; m_hdr = '0; m_sub = '0;
        end else begin
            m_upd  = 0;
            m_cerr = 0;
            avi_ok = 0;
            if (mq.size() != 0 && sample_ready) void'(mq.pop_front());
            if (m_have_ecc) m_ecc = (m_ecc < 255) ? m_ecc + 1 : 255;
            if (m_have) begin
                b0 = sub_byte(m_sub, 0, 0);
                b1 = sub_byte(m_sub, 0, 1);
                case (m_hdr[7:0])
                    8'h01: begin
                        m_cts = {b1[3:0], sub_byte(m_sub, 0, 2), sub_byte(m_sub, 0, 3)};
                        m_n   = {sub_byte(m_sub, 0, 4) & 8'h0F, sub_byte(m_sub, 0, 5), sub_byte(m_sub, 0, 6)} >> 4 << 4
                                | {12'h0, sub_byte(m_sub, 0, 6)};
                        m_n   = {4'(sub_byte(m_sub, 0, 4)), sub_byte(m_sub, 0, 5), sub_byte(m_sub, 0, 6)};
                        m_upd = 1;
                    end
                    8'h03: begin
                        if (b0[0] && !b0[4]) m_avmute = 1;
                        if (b0[4] && !b0[0]) m_avmute = 0;
                        m_cd = b1[3:0];
                        m_pp = b1[7:4];
                    end
                    8'h82: begin
                        sum = m_hdr[7:0] + m_hdr[15:8] + m_hdr[23:16];
                        for (int k = 0; k < 4; k++)
                            for (int i = 0; i < 7; i++) sum = sum + sub_byte(m_sub, k, i);
                        if (sum == 8'h00) begin
                            avi_ok   = 1;
                            m_vic    = 7'(sub_byte(m_sub, 0, 4));
                            m_fields = 0;
                        end else begin
                            m_cerr = 1;
                        end
                    end
                    8'h02: begin
                        pres = m_hdr[11:8];
                        if (pres != 0) begin
                            if (mq.size() != 0) m_ovf = 1;
                            else
                                for (int k = 0; k < 4; k++)
                                    if (pres[k]) begin
                                        e.l = m_sub[56*k +: 24];
                                        e.r = m_sub[56*k + 24 +: 24];
                                        mq.push_back(e);
                                    end
                        end
                    end
                    default: ;
                endcase
            end
            if (video_field_end && !avi_ok && m_fields < 2) m_fields++;
            m_have     = pkt_valid && !pkt_ecc_err;
            m_have_ecc = pkt_valid && pkt_ecc_err;
            m_hdr      = pkt_header;
            m_sub      = pkt_sub;
        end
    end

    always @(negedge clk_pixel) begin : compare
        logic [23:0] t;
        if (!reset) begin
            chk("acr_N", acr_N, m_n);
            chk("acr_CTS", acr_CTS, m_cts);
            chk("acr_update", acr_update, m_upd);
            chk("avmute", avmute, m_avmute);
            chk("gcp_cd_field", gcp_cd_field, m_cd);
            chk("gcp_pp_field", gcp_pp_field, m_pp);
            chk("vic", vic, m_vic);
            chk("avi_valid", avi_valid, (m_fields < 2));
            chk("avi_checksum_err", avi_checksum_err, m_cerr);
            chk("sample_overflow", sample_overflow, m_ovf);
            chk("ecc_drop_count", ecc_drop_count, m_ecc);
            chk("sample_valid", sample_valid, (mq.size() != 0));
            if (mq.size() != 0) begin
                t = mq[0].l;
                chk("sample_left", sample_left, t[23 -: AW]);
                t = mq[0].r;
                chk("sample_right", sample_right, t[23 -: AW]);
            end
        end
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
        pkt_valid       = 1'b0;
        pkt_ecc_err     = 1'b0;
        video_field_end = 1'b0;
    endtask

    task automatic send(input logic [23:0] h, input logic [223:0] s, input logic e);
        pkt_header  = h;
        pkt_sub     = s;
        pkt_ecc_err = e;
        pkt_valid   = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [223:0] s, s_acr, sa, sb;
        int n;
        repeat (3) @(posedge clk_pixel);
        #1;
        reset = 1'b0;
        chk("rst avi_valid", avi_valid, 0);
        chk("rst sample_valid", sample_valid, 0);
        chk("rst acr_N", acr_N, 0);
        chk("rst ecc_drop_count", ecc_drop_count, 0);
        chk("rst avmute", avmute, 0);
        chk("rst sample_overflow", sample_overflow, 0);

        // ACR
        s_acr = '0;
        s_acr[15:8] = 8'h01; s_acr[23:16] = 8'h86; s_acr[31:24] = 8'hA0; s_acr[47:40] = 8'h18;
        send(24'h000001, s_acr, 1'b0);
        tick();
        chk("t1 acr_CTS", acr_CTS, 20'h186A0);
        chk("t1 acr_N", acr_N, 20'h01800);
        chk("t1 acr_update", acr_update, 1);
        tick();
        chk("t1 acr_update low", acr_update, 0);

        // Audio, samples 0 and 2 present
        sample_ready = 1'b1;
        s = '0;
        s[23:0] = 24'h123400; s[47:24] = 24'hABCD00;
        s[112 +: 24] = 24'h5A5A00; s[136 +: 24] = 24'h0F0F00;
        send(24'h000502, s, 1'b0);
        tick();
        chk("t2 valid0", sample_valid, 1);
        chk("t2 left0", sample_left, 16'h1234);
        chk("t2 right0", sample_right, 16'hABCD);
        tick();
        chk("t2 valid1", sample_valid, 1);
        chk("t2 left1", sample_left, 16'h5A5A);
        chk("t2 right1", sample_right, 16'h0F0F);
        tick();
        chk("t2 valid end", sample_valid, 0);

        // Backpressure and overflow
        sample_ready = 1'b0;
        sa = '0; sb = '0;
        for (int k = 0; k < 4; k++) begin
            sa[56*k +: 24]      = 24'(24'h111100 * (k + 1));
            sa[56*k + 24 +: 24] = 24'(24'h0A0000 + 24'(k) * 24'h000100);
            sb[56*k +: 24]      = 24'h777700;
            sb[56*k + 24 +: 24] = 24'h666600;
        end
        send(24'h000F02, sa, 1'b0);
        repeat (31) tick();
        chk("t3 stalled left", sample_left, 16'h1111);
        send(24'h000F02, sb, 1'b0);
        tick();
        chk("t3 overflow", sample_overflow, 1);
        chk("t3 still left", sample_left, 16'h1111);
        sample_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (sample_valid) n++;
            tick();
        end
        chk("t3 drained count", n, 4);
        chk("t3 overflow sticky", sample_overflow, 1);

        // GCP
        s = '0; s[7:0] = 8'h01; s[15:8] = 8'h45;
        send(24'h000003, s, 1'b0);
        tick();
        chk("t4 avmute set", avmute, 1);
        chk("t4 cd", gcp_cd_field, 4'h5);
        chk("t4 pp", gcp_pp_field, 4'h4);
        s[7:0] = 8'h11;
        send(24'h000003, s, 1'b0);
        tick();
        chk("t4 avmute both", avmute, 1);
        s[7:0] = 8'h10;
        send(24'h000003, s, 1'b0);
        tick();
        chk("t4 avmute clear", avmute, 0);

        // AVI: checksum byte 0x5F balances 0x82+0x02+0x0D+0x10
        s = '0; s[7:0] = 8'h5F; s[39:32] = 8'h10;
        send(24'h0D0282, s, 1'b0);
        tick();
        chk("t5 vic", vic, 7'd16);
        chk("t5 avi_valid", avi_valid, 1);
        video_field_end = 1'b1;
        tick();
        chk("t5 after field1", avi_valid, 1);
        video_field_end = 1'b1;
        tick();
        chk("t5 after field2", avi_valid, 0);
        s[39:32] = 8'h04;
        send(24'h0D0282, s, 1'b0);
        tick();
        chk("t5 cksum err", avi_checksum_err, 1);
        chk("t5 vic kept", vic, 7'd16);
        chk("t5 avi_valid kept", avi_valid, 0);
        tick();
        chk("t5 cksum err low", avi_checksum_err, 0);

        // ECC drops, back to back
        s = '0; s[15:8] = 8'h02; s[23:16] = 8'h22;
        repeat (300) send(24'h000001, s, 1'b1);
        tick();
        tick();
        chk("t6 ecc saturate", ecc_drop_count, 8'd255);
        chk("t6 acr kept", acr_CTS, 20'h186A0);

        // Reset with samples pending
        sample_ready = 1'b0;
        send(24'h000702, sa, 1'b0);
        tick();
        chk("t6 pending", sample_valid, 1);
        reset = 1'b1;
        #1;
        chk("t6 rst sample_valid", sample_valid, 0);
        chk("t6 rst acr_N", acr_N, 0);
        chk("t6 rst acr_CTS", acr_CTS, 0);
        chk("t6 rst ecc", ecc_drop_count, 0);
        chk("t6 rst overflow", sample_overflow, 0);
        chk("t6 rst vic", vic, 0);
        chk("t6 rst avi_valid", avi_valid, 0);
        chk("t6 rst cd", gcp_cd_field, 0);
        @(posedge clk_pixel);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        chk("t6 post rst valid", sample_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
